// File: rtl/cnn_pkg.sv
// Shared types, image geometry and the step-to-pixel mapping for the CNN frame
// sequencer.
package cnn_pkg;

    localparam int IMG_DIM     = 64;
    localparam int BLK         = 8;
    localparam int BLK_PER_ROW = IMG_DIM / BLK;
    localparam int NUM_UNITS   = BLK_PER_ROW * BLK_PER_ROW;
    localparam int NUM_STEPS   = IMG_DIM * IMG_DIM;
    localparam int UNIT_W      = $clog2(NUM_UNITS);
    localparam int OFF_W       = $clog2(BLK);
    localparam int BCOORD_W    = $clog2(BLK_PER_ROW);
    localparam int STEP_W      = 2 * $clog2(IMG_DIM);
    localparam int COORD_W     = $clog2(IMG_DIM) + 1;

    typedef enum logic [2:0] {IDLE, SCAN, DRAIN, FC_WAIT, DONE} state_t;

    typedef struct packed {
        logic [COORD_W-1:0] row;
        logic [COORD_W-1:0] col;
    } coord_t;

    // Low step bits pick the unit (block); the upper bits are the offset inside
    // the block, so every unit is visited before the offset advances.
    function automatic coord_t step_coord(input logic [STEP_W-1:0] s);
        logic [UNIT_W-1:0] u;
        logic [OFF_W-1:0]  ii;
        logic [OFF_W-1:0]  jj;
        coord_t            c;
        u     = s[UNIT_W-1:0];
        jj    = s[UNIT_W +: OFF_W];
        ii    = s[UNIT_W+OFF_W +: OFF_W];
        c.row = COORD_W'({u[UNIT_W-1 -: BCOORD_W], ii});
        c.col = COORD_W'({u[BCOORD_W-1:0], jj});
        return c;
    endfunction

endpackage

// File: rtl/cnn_strobe_delay.sv
// PIPE_LAT-deep shift of {valid, unit}: turns each issue strobe into the matching
// accumulate strobe without recomputing the unit index.
module cnn_strobe_delay
    import cnn_pkg::*;
#(
    parameter int PIPE_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_vld,
    input  logic [UNIT_W-1:0] in_unit,
    output logic              out_vld,
    output logic [UNIT_W-1:0] out_unit
);

    logic [PIPE_LAT-1:0] vld_p;
    logic [UNIT_W-1:0]   unit_p [PIPE_LAT];

    // Only the valid bits need clearing; stale unit data is never qualified.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p <= '0;
        end else if (clr) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= in_vld;
            for (int i = 1; i < PIPE_LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        unit_p[0] <= in_unit;
        for (int i = 1; i < PIPE_LAT; i++) begin
            unit_p[i] <= unit_p[i-1];
        end
    end

    assign out_vld  = vld_p[PIPE_LAT-1];
    assign out_unit = unit_p[PIPE_LAT-1];

endmodule

// File: rtl/cnn_scan_sequencer.sv
// Frame controller: scans the image step by step, routes each ALU result to its
// pooling unit, launches the FC layer and reports completion.
module cnn_scan_sequencer
    import cnn_pkg::*;
#(
    parameter int PIX_CYC  = 16,
    parameter int PIPE_LAT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 fc_done,
    output logic [COORD_W-1:0]   row,
    output logic [COORD_W-1:0]   col,
    output logic                 iss_stb,
    output logic [UNIT_W-1:0]    unit_idx,
    output logic [NUM_UNITS-1:0] unit_en,
    output logic                 acc_stb,
    output logic                 fc_start,
    output logic                 busy,
    output logic                 done
);

    localparam int                CYC_W     = (PIX_CYC > 1) ? $clog2(PIX_CYC) : 1;
    localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(PIX_CYC - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(NUM_STEPS - 1);

    state_t            state;
    state_t            state_nxt;
    logic [CYC_W-1:0]  cyc;
    logic [STEP_W-1:0] step;
    coord_t            coord_nxt;
    logic              issue;
    logic              dly_vld;
    logic [UNIT_W-1:0] dly_unit;
    logic [UNIT_W-1:0] unit_hold;

    assign issue     = (state == SCAN) && (cyc == '0);
    assign coord_nxt = step_coord(step + 1'b1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // SCAN ends on the issue of the last step; since PIPE_LAT < PIX_CYC every
    // earlier result has already landed, so the first strobe seen in DRAIN is
    // the final one.
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = SCAN;
                SCAN:    if (issue && (step == STEP_LAST)) state_nxt = DRAIN;
                DRAIN:   if (dly_vld) state_nxt = FC_WAIT;
                FC_WAIT: if (fc_done) state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        iss_stb  = issue;
        acc_stb  = dly_vld;
        busy     = (state != IDLE);
        done     = (state == DONE);
        unit_idx = dly_vld ? dly_unit : unit_hold;
        unit_en  = '0;
        if (dly_vld) begin
            unit_en[dly_unit] = 1'b1;
        end
    end

    // Step/cycle counters; row/col load together with the step so they are
    // already valid on the issue cycle and hold for the rest of the step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc  <= '0;
            step <= '0;
            row  <= '0;
            col  <= '0;
        end else if (abort || (state == IDLE)) begin
            cyc  <= '0;
            step <= '0;
            if (!abort && start) begin
                row <= '0;
                col <= '0;
            end
        end else if (state == SCAN) begin
            if (cyc == CYC_LAST) begin
                cyc  <= '0;
                step <= step + 1'b1;
                row  <= coord_nxt.row;
                col  <= coord_nxt.col;
            end else begin
                cyc <= cyc + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            unit_hold <= '0;
            fc_start  <= 1'b0;
        end else begin
            if (dly_vld) begin
                unit_hold <= dly_unit;
            end
            fc_start <= !abort && (state == DRAIN) && dly_vld;
        end
    end

    cnn_strobe_delay #(
        .PIPE_LAT (PIPE_LAT)
    ) u_strobe_delay (
        .clk      (clk),
        .rst      (rst),
        .clr      (abort),
        .in_vld   (issue),
        .in_unit  (step[UNIT_W-1:0]),
        .out_vld  (dly_vld),
        .out_unit (dly_unit)
    );

endmodule

// File: tb/tb_cnn_scan_sequencer.sv
// Bench for cnn_scan_sequencer: time-based frame model checked every cycle, plus
// literal spot checks and a short-timing second instance for reset in DRAIN.
module tb_cnn_scan_sequencer;

    localparam int PIX   = 16;
    localparam int LAT   = 4;
    localparam int STEPS = 4096;
    localparam int LASTN = PIX * (STEPS - 1);
    localparam int FCN   = LASTN + LAT + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, abort = 1'b0, fc_done = 1'b0;
    logic [6:0]  row, col;
    logic        iss_stb, acc_stb, fc_start, busy, done;
    logic [5:0]  unit_idx;
    logic [63:0] unit_en;

    logic        rst2 = 1'b1, start2 = 1'b0;
    logic [6:0]  row2, col2;
    logic        iss2, acc2, fc_start2, busy2, done2;
    logic [5:0]  unit_idx2;
    logic [63:0] unit_en2;

    int tests = 0;
    int fails = 0;
    int iss_cnt = 0;
    int acc_cnt = 0;
    bit dut2_fin = 1'b0;

    // model state
    bit busy_m = 1'b0, done_m = 1'b0;
    int n_m = 0, ni = 0;
    int row_m = 0, col_m = 0, unit_m = 0;
    bit e_iss, e_acc, e_fc;

    cnn_scan_sequencer #(.PIX_CYC(PIX), .PIPE_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .fc_done(fc_done),
        .row(row), .col(col), .iss_stb(iss_stb), .unit_idx(unit_idx),
        .unit_en(unit_en), .acc_stb(acc_stb), .fc_start(fc_start),
        .busy(busy), .done(done)
    );

    cnn_scan_sequencer #(.PIX_CYC(4), .PIPE_LAT(3)) dut2 (
        .clk(clk), .rst(rst2), .start(start2), .abort(1'b0), .fc_done(1'b0),
        .row(row2), .col(col2), .iss_stb(iss2), .unit_idx(unit_idx2),
        .unit_en(unit_en2), .acc_stb(acc2), .fc_start(fc_start2),
        .busy(busy2), .done(done2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic int exp_row(input int s);
        return ((s % 64) / 8) * 8 + s / 512;
    endfunction

    function automatic int exp_col(input int s);
        return ((s % 64) % 8) * 8 + (s / 64) % 8;
    endfunction

    // Model: everything follows from n = cycles since the first issue strobe.
    always @(negedge clk) begin
        e_iss = 1'b0;
        e_acc = 1'b0;
        e_fc  = 1'b0;
        if (rst) begin
            busy_m = 1'b0; done_m = 1'b0;
            row_m = 0; col_m = 0; unit_m = 0;
        end else if (busy_m && !done_m) begin
            if (n_m <= LASTN && n_m % PIX == 0) begin
                e_iss = 1'b1;
                row_m = exp_row(n_m / PIX);
                col_m = exp_col(n_m / PIX);
            end
            ni = n_m - LAT;
            if (ni >= 0 && ni <= LASTN && ni % PIX == 0) begin
                e_acc = 1'b1;
                unit_m = (ni / PIX) % 64;
            end
            e_fc = (n_m == FCN);
        end
        chk("m_iss", 64'(iss_stb), 64'(e_iss));
        chk("m_acc", 64'(acc_stb), 64'(e_acc));
        chk("m_fc_start", 64'(fc_start), 64'(e_fc));
        chk("m_busy", 64'(busy), 64'(busy_m));
        chk("m_done", 64'(done), 64'(done_m));
        chk("m_row", 64'(row), 64'(row_m));
        chk("m_col", 64'(col), 64'(col_m));
        chk("m_unit_idx", 64'(unit_idx), 64'(unit_m));
        chk("m_unit_en", unit_en, e_acc ? (64'd1 << unit_m) : 64'd0);
        if (iss_stb === 1'b1) iss_cnt++;
        if (acc_stb === 1'b1) acc_cnt++;
        if (!rst) begin
            if (abort) begin
                busy_m = 1'b0; done_m = 1'b0;
            end else if (!busy_m) begin
                if (start) begin
                    busy_m = 1'b1; n_m = 0;
                end
            end else if (done_m) begin
                busy_m = 1'b0; done_m = 1'b0;
            end else begin
                if (n_m >= FCN && fc_done) done_m = 1'b1;
                n_m++;
            end
        end
    end

    task automatic scen1();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("s1_first_iss", 64'(iss_stb), 64'd1);
        chk("s1_first_row", 64'(row), 64'd0);
        chk("s1_first_col", 64'(col), 64'd0);
        repeat (15) tick();
        chk("s1_gap_iss", 64'(iss_stb), 64'd0);
        tick();
        chk("s1_second_iss", 64'(iss_stb), 64'd1);
        chk("s1_second_row", 64'(row), 64'd0);
        chk("s1_second_col", 64'(col), 64'd8);
        repeat (4) tick();
        chk("s1_second_acc", 64'(acc_stb), 64'd1);
        chk("s1_second_unit", 64'(unit_idx), 64'd1);
        chk("s1_second_en", unit_en, 64'h2);
    endtask

    initial begin : main
        int n;
        int a0;
        int k;
        repeat (3) tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_row", 64'(row), 64'd0);
        chk("rst_unit_en", unit_en, 64'd0);
        rst = 1'b0;
        tick();

        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("start_abort_busy", 64'(busy), 64'd0);
        tick();
        chk("start_abort_iss", 64'(iss_stb), 64'd0);

        // frame aborted inside step 1000 while its result is still in flight
        scen1();
        n = 20;
        while (n < 16001) begin
            start   = ($urandom_range(0, 63) == 0);
            fc_done = ($urandom_range(0, 31) == 0);
            tick();
            n++;
        end
        start = 1'b0; fc_done = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_iss", 64'(iss_stb), 64'd0);
        a0 = acc_cnt;
        repeat (20) tick();
        chk("abort_no_acc", 64'(acc_cnt), 64'(a0));

        repeat ($urandom_range(1, 10)) tick();
        iss_cnt = 0;
        acc_cnt = 0;
        scen1();
        n = 20;
        while (n < 70000 && fc_start !== 1'b1) begin
            start   = (n < 65000) && ($urandom_range(0, 63) == 0);
            fc_done = (n < 65000) && ($urandom_range(0, 31) == 0);
            tick();
            n++;
            if (n == 1024) begin
                chk("step64_iss", 64'(iss_stb), 64'd1);
                chk("step64_row", 64'(row), 64'd0);
                chk("step64_col", 64'(col), 64'd1);
            end
            if (n == LASTN) begin
                chk("step4095_row", 64'(row), 64'd63);
                chk("step4095_col", 64'(col), 64'd63);
            end
        end
        start = 1'b0; fc_done = 1'b0;
        chk("fc_start_latency", 64'(n), 64'd65525);
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("fc_wait_busy", 64'(busy), 64'd1);
            chk("fc_wait_done", 64'(done), 64'd0);
        end
        chk("frame_iss_count", 64'(iss_cnt), 64'd4096);
        chk("frame_acc_count", 64'(acc_cnt), 64'd4096);
        fc_done = 1'b1;
        tick();
        fc_done = 1'b0;
        chk("done_pulse", 64'(done), 64'd1);
        tick();
        chk("done_after", 64'(done), 64'd0);
        chk("busy_after", 64'(busy), 64'd0);

        k = 0;
        while (!dut2_fin && k < 30000) begin
            tick();
            k++;
        end
        chk("dut2_finished", 64'(dut2_fin), 64'd1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Second instance: reset asserted while the final result is still draining.
    initial begin : dut2_proc
        int cnt_i;
        int cnt_a;
        int k;
        bit stray;
        repeat (3) tick();
        rst2 = 1'b0;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        cnt_i = 0; cnt_a = 0; k = 0;
        while (k < 20000) begin
            if (iss2 === 1'b1) cnt_i++;
            if (acc2 === 1'b1) cnt_a++;
            if (cnt_i == 4096) break;
            tick();
            k++;
        end
        chk("d2_iss_count", 64'(cnt_i), 64'd4096);
        chk("d2_last_row", 64'(row2), 64'd63);
        chk("d2_last_col", 64'(col2), 64'd63);
        tick();
        chk("d2_drain_busy", 64'(busy2), 64'd1);
        chk("d2_drain_acc", 64'(acc2), 64'd0);
        chk("d2_acc_count", 64'(cnt_a), 64'd4095);
        rst2 = 1'b1;
        #1;
        chk("d2_rst_busy", 64'(busy2), 64'd0);
        chk("d2_rst_row", 64'(row2), 64'd0);
        chk("d2_rst_col", 64'(col2), 64'd0);
        chk("d2_rst_unit", 64'(unit_idx2), 64'd0);
        chk("d2_rst_en", unit_en2, 64'd0);
        chk("d2_rst_strobes", 64'({iss2, acc2, fc_start2, done2}), 64'd0);
        tick();
        rst2 = 1'b0;
        stray = 1'b0;
        repeat (10) begin
            tick();
            if (acc2 !== 1'b0 || busy2 !== 1'b0 || fc_start2 !== 1'b0) stray = 1'b1;
        end
        chk("d2_quiet_after_rst", 64'(stray), 64'd0);
        dut2_fin = 1'b1;
    end

endmodule
